ram_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters: the CPU load/store path (cpu_*) and a debug/loader port (dbg_*) that inspects or preloads memory.
- Accepts at most one access per clk, round-robin when both request, and routes read data back to the issuing requester after a fixed RAM read latency.
- Sits between the CPU datapath and the RAM instance.
- cpu_gnt low is the CPU stall condition for memory instructions.

---
 rtl/ram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one single-port synchronous data RAM between the CPU
//            load/store path (cpu_*) and a debug/loader port (dbg_*).
//            One access per clk, round-robin on contention. Read data is
//            routed back to the issuing requester RD_LAT cycles after grant.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW      address width
//   DW      data width
//   RD_LAT  RAM read latency in clk cycles (legal range 1..4)
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request; fields held until cpu_gnt
//   cpu_gnt                  access accepted this cycle (combinational)
//   cpu_rvalid/rdata         CPU read return
//   dbg_*                    same set for the debug/loader port
//   mem_en/we/addr/wdata     RAM command, muxed from the winner
//   mem_rdata                RAM read data, RD_LAT cycles after a read
//   conflict_cnt             saturating count of cycles with both req high
// Optional feature (macro RAM_ARB_LOCK_EN)
//   Adds cpu_lock/dbg_lock inputs. A transfer with X_lock=1 locks the RAM
//   to X; the other port is starved until X transfers with X_lock=0.
// ============================================================================
module ram_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef RAM_ARB_LOCK_EN
  input  logic          cpu_lock,
  input  logic          dbg_lock,
`endif
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  // Owner of the most recent transfer. Reset to DBG so the CPU wins the
  // first conflict.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  owner_e last_owner, last_owner_nxt;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_CPU  = 2'd1,
    LK_DBG  = 2'd2
  } lock_e;

  lock_e lock_state, lock_nxt;
`endif

  logic both_req;
  logic rd_push;

  // Tag pipeline: one slot per cycle of read latency. tag_vld marks a read
  // in flight, tag_own records who issued it (1 = dbg).
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_own;

  assign both_req = cpu_req & dbg_req;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_DBG;
`ifdef RAM_ARB_LOCK_EN
      lock_state <= LK_NONE;
`endif
    end else begin
      last_owner <= last_owner_nxt;
`ifdef RAM_ARB_LOCK_EN
      lock_state <= lock_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Grant and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_gnt        = 1'b0;
    dbg_gnt        = 1'b0;
    last_owner_nxt = last_owner;
`ifdef RAM_ARB_LOCK_EN
    lock_nxt       = lock_state;
`endif

    // Grants are held low for the whole time reset is asserted, not just
    // after the next edge.
    if (!rst) begin
`ifdef RAM_ARB_LOCK_EN
      if (lock_state == LK_CPU) begin
        cpu_gnt = cpu_req;
      end else if (lock_state == LK_DBG) begin
        dbg_gnt = dbg_req;
      end else
`endif
      begin
        if (both_req) begin
          if (last_owner == OWN_DBG) begin
            cpu_gnt = 1'b1;
          end else begin
            dbg_gnt = 1'b1;
          end
        end else begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req;
        end
      end
    end

    if (cpu_gnt) begin
      last_owner_nxt = OWN_CPU;
    end else if (dbg_gnt) begin
      last_owner_nxt = OWN_DBG;
    end

`ifdef RAM_ARB_LOCK_EN
    // Only the lock holder (or anyone, when unlocked) can transfer, so the
    // granted port's lock bit alone decides the next lock state.
    if (cpu_gnt) begin
      lock_nxt = cpu_lock ? LK_CPU : LK_NONE;
    end else if (dbg_gnt) begin
      lock_nxt = dbg_lock ? LK_DBG : LK_NONE;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // RAM command mux
  // --------------------------------------------------------------------------
  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
  assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

  assign rd_push   = mem_en & ~mem_we;

  // --------------------------------------------------------------------------
  // Read-return tag pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= rd_push;
      tag_own[0] <= dbg_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign cpu_rvalid = tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
  assign dbg_rvalid = tag_vld[RD_LAT-1] &  tag_own[RD_LAT-1];

  // Read data is qualified by rvalid, so both ports see the RAM bus directly.
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

  // --------------------------------------------------------------------------
  // Conflict counter (saturating)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'h0000;
    end else if (both_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. A behavioural RAM drives
//            mem_rdata; a reference model (shadow memory, round-robin rule,
//            queue of expected read returns) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   conflict_cnt;
`ifdef RAM_ARB_LOCK_EN
  logic          cpu_lock, dbg_lock;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
`ifdef RAM_ARB_LOCK_EN
    .cpu_lock(cpu_lock), .dbg_lock(dbg_lock),
`endif
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Behavioural single-port RAM with LAT-cycle read latency.
  logic [DW-1:0] ram     [0:15];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[3:0]] <= mem_wdata;
    rd_pipe[0] <= ram[mem_addr[3:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state
  typedef struct {
    int          due;
    bit          own;   // 1 = dbg
    logic [15:0] data;
  } ret_t;

  ret_t        q[$];
  logic [15:0] shadow [0:15];
  bit          m_last;   // 1 = dbg transferred last
  int          m_lock;   // 0 none, 1 cpu, 2 dbg
  int          m_cnt;
  int          cyc;
  bit          g_c, g_d;  // model grants of the last step
  logic        obs_c, obs_d;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  // One clock cycle: inputs are already applied (posedge+1). Checks at
  // posedge+3, then advances the model and the clock.
  task automatic step();
    bit          eg_c, eg_d, rv_c, rv_d, we;
    logic [15:0] rd, wd;
    logic [3:0]  a;
    ret_t        r;
    #2;
    eg_c = 0; eg_d = 0;
    if (m_lock == 1)                eg_c = cpu_req;
    else if (m_lock == 2)           eg_d = dbg_req;
    else if (cpu_req && dbg_req) begin
      if (m_last) eg_c = 1; else eg_d = 1;
    end else begin
      eg_c = cpu_req; eg_d = dbg_req;
    end
    obs_c = cpu_gnt; obs_d = dbg_gnt;
    chk("cpu_gnt", cpu_gnt, eg_c);
    chk("dbg_gnt", dbg_gnt, eg_d);
    chk("mem_en", mem_en, eg_c | eg_d);
    if (eg_c | eg_d) begin
      we = eg_c ? cpu_we : dbg_we;
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, eg_c ? cpu_addr : dbg_addr);
      if (we) chk("mem_wdata", mem_wdata, eg_c ? cpu_wdata : dbg_wdata);
    end else begin
      chk("mem_we_idle", mem_we, 0);
    end

    rv_c = 0; rv_d = 0; rd = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].own) rv_d = 1; else rv_c = 1;
      rd = q[0].data;
      void'(q.pop_front());
    end
    chk("cpu_rvalid", cpu_rvalid, rv_c);
    chk("dbg_rvalid", dbg_rvalid, rv_d);
    if (rv_c) chk("cpu_rdata", cpu_rdata, rd);
    if (rv_d) chk("dbg_rdata", dbg_rdata, rd);
    chk("conflict_cnt", conflict_cnt, m_cnt);

    if (cpu_req && dbg_req && m_cnt < 65535) m_cnt++;
    if (eg_c | eg_d) begin
      we = eg_c ? cpu_we : dbg_we;
      a  = eg_c ? cpu_addr[3:0] : dbg_addr[3:0];
      wd = eg_c ? cpu_wdata : dbg_wdata;
      if (we) shadow[a] = wd;
      else begin
        r.due = cyc + LAT; r.own = eg_d; r.data = shadow[a];
        q.push_back(r);
      end
      m_last = eg_d;
`ifdef RAM_ARB_LOCK_EN
      if (eg_c) m_lock = cpu_lock ? 1 : 0;
      else      m_lock = dbg_lock ? 2 : 0;
`endif
    end
    g_c = eg_c; g_d = eg_d;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Asserts reset at posedge+1 for 'hold' edges; in-flight reads vanish.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    #2;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_last = 1; m_lock = 0; m_cnt = 0;
    cyc += hold;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_cpu(1, 0, 0, 0);
    set_dbg(1, 0, 0, 0);
`ifdef RAM_ARB_LOCK_EN
    cpu_lock = 0; dbg_lock = 0;
`endif
    cyc = 0; m_last = 1; m_lock = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset with both requests high: no grants may leak out.
    do_reset(1);

    // Preload every RAM word through the debug port; RAM[5] = BEEF.
    set_cpu(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      set_dbg(1, 1, 16'(i), (i == 5) ? 16'hBEEF : (16'(i) * 16'h0101) ^ 16'h5A5A);
      step();
    end
    set_dbg(0, 0, 0, 0);

    // Single requester read of BEEF.
    set_cpu(1, 0, 16'h0005, 0);
    step();
    set_cpu(0, 0, 0, 0);
    repeat (LAT + 1) step();

    // Contention from reset: alternation starting with cpu, 6 conflicts.
    do_reset(1);
    set_cpu(1, 0, 16'h0001, 0);
    set_dbg(1, 0, 16'h0002, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("contention_cpu_order", obs_c, (k % 2) == 0);
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    repeat (LAT + 1) step();
    chk("conflict_after_6", conflict_cnt, 6);

    // Debug write then CPU read of the same address.
    set_dbg(1, 1, 16'h0003, 16'h1234);
    step();
    set_dbg(0, 0, 0, 0);
    set_cpu(1, 0, 16'h0003, 0);
    step();
    set_cpu(0, 0, 0, 0);
    repeat (LAT + 1) step();

    // Back-to-back reads alternating owner.
    set_cpu(1, 0, 16'h0007, 0); step();
    set_cpu(0, 0, 0, 0);
    set_dbg(1, 0, 16'h0009, 0); step();
    set_dbg(0, 0, 0, 0);
    set_cpu(1, 0, 16'h000A, 0); step();
    set_cpu(0, 0, 0, 0);
    repeat (LAT + 1) step();

    // Reset one cycle after a CPU read grant: the read must never return.
    set_cpu(1, 0, 16'h0004, 0);
    step();
    set_cpu(0, 0, 0, 0);
    do_reset(2);
    repeat (LAT + 1) step();
    set_cpu(1, 0, 16'h0002, 0);
    set_dbg(1, 0, 16'h0006, 0);
    step();
    chk("post_reset_cpu_wins", obs_c, 1);
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    repeat (LAT + 1) step();

`ifdef RAM_ARB_LOCK_EN
    // Debug locked read-modify-write while the CPU keeps requesting.
    set_cpu(1, 0, 16'h0001, 0);
    step();
    set_dbg(1, 0, 16'h0002, 0); dbg_lock = 1;
    step();
    chk("lock_rd_cpu_gnt", obs_c, 0);
    chk("lock_rd_dbg_gnt", obs_d, 1);
    set_dbg(1, 1, 16'h0002, 16'hCAFE); dbg_lock = 0;
    step();
    chk("lock_wr_cpu_gnt", obs_c, 0);
    chk("lock_wr_dbg_gnt", obs_d, 1);
    set_dbg(0, 0, 0, 0);
    step();
    chk("lock_release_cpu_gnt", obs_c, 1);
    set_cpu(0, 0, 0, 0);
    repeat (LAT + 1) step();
`endif

    // Randomised traffic; a request keeps its fields until granted.
    g_c = 0; g_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset(1);
        g_c = 0; g_d = 0;
      end
      if (!cpu_req || g_c) begin
        set_cpu($urandom_range(0, 99) < 65, 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
`ifdef RAM_ARB_LOCK_EN
        cpu_lock = $urandom_range(0, 99) < 15;
`endif
      end
      if (!dbg_req || g_d) begin
        set_dbg($urandom_range(0, 99) < 65, 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
`ifdef RAM_ARB_LOCK_EN
        dbg_lock = $urandom_range(0, 99) < 15;
`endif
      end
      step();
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    repeat (LAT + 1) step();
    chk("return_queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
